// File: rtl/mem_responder_if.sv
// Word memory request bus between a processor (master) and a memory responder (slave).
interface mem_responder_if;
  logic [31:0] mem_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_ack;
  logic        mem_busy;

  modport master (
    output mem_addr, mem_rd_req, mem_wr_req, mem_wr_data,
    input  mem_rd_data, mem_ack, mem_busy
  );

  modport slave (
    input  mem_addr, mem_rd_req, mem_wr_req, mem_wr_data,
    output mem_rd_data, mem_ack, mem_busy
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: one request in service at a time, plus an
// out-of-band write port for loading the array while the processor runs.
module mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4096
) (
  input  logic               clk,
  input  logic               rst,
  mem_responder_if.slave     bus,
  output logic               req_dropped,
  input  logic               oob_wen,
  input  logic [31:0]        oob_wr_addr,
  input  logic [31:0]        oob_wr_data
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [29:0] idx_q;
  logic [31:0] data_q;
  logic        op_wr_q;
  logic        ack_q;
  logic        busy_q;
  logic        dropped_q;
  logic [31:0] rd_data_q;

  logic [31:0] mem_q [DEPTH];

  logic        req_any;
  logic        finish;
  logic        in_range;
  logic [29:0] oob_idx;
  logic        oob_in_range;
  logic        wr_commit;
  logic        unused_addr_lsbs;

  assign req_any          = bus.mem_rd_req | bus.mem_wr_req;
  assign finish           = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign in_range         = idx_q < DEPTH_W;
  assign oob_idx          = oob_wr_addr[31:2];
  assign oob_in_range     = oob_idx < DEPTH_W;
  assign wr_commit        = finish && op_wr_q && in_range;
  assign unused_addr_lsbs = ^{bus.mem_addr[1:0], oob_wr_addr[1:0]};

  // Request sequencer: accept in IDLE/ACK, count down in WAIT, pulse ack on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= 30'd0;
      data_q    <= 32'd0;
      op_wr_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      ack_q     <= 1'b0;
      dropped_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ACK: begin
          if (req_any) begin
            // Write wins when both requests arrive together; the read is simply lost.
            idx_q   <= bus.mem_addr[31:2];
            data_q  <= bus.mem_wr_data;
            op_wr_q <= bus.mem_wr_req;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (req_any) begin
            dropped_q <= 1'b1;
          end else begin
            dropped_q <= 1'b0;
          end
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= ST_ACK;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            if (!op_wr_q) begin
              rd_data_q <= in_range ? mem_q[idx_q[AW-1:0]] : 32'h0000_0000;
            end else begin
              rd_data_q <= rd_data_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Word array, never reset; the front-door commit is last so it wins a same-word clash.
  always_ff @(posedge clk) begin
    if (oob_wen && oob_in_range) begin
      mem_q[oob_idx[AW-1:0]] <= oob_wr_data;
    end
    if (wr_commit) begin
      mem_q[idx_q[AW-1:0]] <= data_q;
    end
  end

  assign bus.mem_ack     = ack_q;
  assign bus.mem_busy    = busy_q;
  assign bus.mem_rd_data = rd_data_q;
  assign req_dropped     = dropped_q;

endmodule

// File: tb/tb_mem_responder.sv
// Drives one stimulus stream into a LATENCY=4 and a LATENCY=1 responder and scores
// both against a transaction-level model of the memory.
module tb_mem_responder;
  localparam int DEPTH = 4096;
  localparam int LAT0  = 4;
  localparam int LAT1  = 1;

  typedef struct {
    int          ack_at;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        t_rst = 1'b0;
  logic        t_rd = 1'b0, t_wr = 1'b0, t_oobw = 1'b0;
  logic [31:0] t_addr = 32'd0, t_wd = 32'd0, t_oa = 32'd0, t_od = 32'd0;
  logic        drop0, drop1;

  mem_responder_if if0 ();
  mem_responder_if if1 ();

  assign if0.mem_addr = t_addr;  assign if0.mem_rd_req = t_rd;
  assign if0.mem_wr_req = t_wr;  assign if0.mem_wr_data = t_wd;
  assign if1.mem_addr = t_addr;  assign if1.mem_rd_req = t_rd;
  assign if1.mem_wr_req = t_wr;  assign if1.mem_wr_data = t_wd;

  mem_responder #(.LATENCY(LAT0), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(t_rst), .bus(if0.slave), .req_dropped(drop0),
    .oob_wen(t_oobw), .oob_wr_addr(t_oa), .oob_wr_data(t_od));
  mem_responder #(.LATENCY(LAT1), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(t_rst), .bus(if1.slave), .req_dropped(drop1),
    .oob_wen(t_oobw), .oob_wr_addr(t_oa), .oob_wr_data(t_od));

  always #5 clk = ~clk;

  // reference model state, one copy per DUT
  logic [31:0] ref_mem [2][DEPTH];
  bit          have_pend [2];
  bit          pend_wr [2];
  int          pend_at [2];
  int          free_at [2];
  int          drop_at [2];
  logic [29:0] pend_idx [2];
  logic [31:0] pend_data [2];
  logic [31:0] last_rd [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          edge_n = 0;
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d edge %0d: got %h, want %h", name, k, edge_n, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    have_pend[k] = 1'b0;
    free_at[k]   = 0;
    drop_at[k]   = -1;
    last_rd[k]   = 32'd0;
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  // One rising edge of the model, using the inputs that were stable at that edge.
  task automatic model_step();
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      bit   do_commit;
      exp_t e;
      do_commit = 1'b0;
      if (!t_rst) begin
        model_reset(k);
      end else if (have_pend[k] && pend_at[k] == edge_n) begin
        have_pend[k] = 1'b0;
        if (pend_wr[k]) do_commit = (int'(pend_idx[k]) < DEPTH);
        else last_rd[k] = (int'(pend_idx[k]) < DEPTH) ? ref_mem[k][int'(pend_idx[k])] : 32'h0;
        e.ack_at = edge_n;
        e.data   = last_rd[k];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (t_oobw && int'(t_oa[31:2]) < DEPTH) ref_mem[k][int'(t_oa[31:2])] = t_od;
      if (do_commit) ref_mem[k][int'(pend_idx[k])] = pend_data[k];
      if (t_rst && (t_rd || t_wr)) begin
        if (edge_n >= free_at[k]) begin
          have_pend[k] = 1'b1;
          pend_at[k]   = edge_n + lat_of(k);
          free_at[k]   = edge_n + lat_of(k) + 1;
          pend_wr[k]   = t_wr;
          pend_idx[k]  = t_addr[31:2];
          pend_data[k] = t_wd;
        end else begin
          drop_at[k] = edge_n;
        end
      end
    end
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic ow, input logic [31:0] oa, input logic [31:0] od, input logic rs);
    @(negedge clk);
    t_rd = rd; t_wr = wr; t_addr = a; t_wd = wd;
    t_oobw = ow; t_oa = oa; t_od = od; t_rst = rs;
    if (!rs) begin
      model_reset(0);
      model_reset(1);
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic oob(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, a, d, 1'b1);
  endtask

  task automatic check_dut(input int k, input logic a, input logic b, input logic d, input logic [31:0] r);
    exp_t f;
    bit   has;
    bit   exp_ack;
    has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (has) f = (k == 0) ? q0[0] : q1[0];
    exp_ack = has && (f.ack_at == edge_n);
    chk("ack", k, {31'd0, a}, {31'd0, exp_ack});
    if (exp_ack) begin
      chk("ack_data", k, r, f.data);
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    chk("busy", k, {31'd0, b}, {31'd0, have_pend[k]});
    chk("req_dropped", k, {31'd0, d}, {31'd0, (drop_at[k] == edge_n)});
    chk("rd_data", k, r, last_rd[k]);
  endtask

  // monitor: samples both DUTs just after every rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check_dut(0, if0.mem_ack, if0.mem_busy, drop0, if0.mem_rd_data);
        check_dut(1, if1.mem_ack, if1.mem_busy, drop1, if1.mem_rd_data);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    model_reset(0);
    model_reset(1);
    mon_en = 1'b1;
    // preload words 0..31 while held in reset
    for (int w = 0; w < 32; w++) begin
      a = (w == 3) ? 32'hDEAD_BEEF : (w == 0) ? 32'h0000_0011 : $urandom;
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'(w * 4), a, 1'b0);
    end
    idle(2);

    rd(32'd12);                   idle(6);
    wr(32'd40, 32'h1234_5678);    idle(4);
    rd(32'd40);                   idle(5);
    rd(32'd41);                   idle(5);
    rd(32'd12); idle(1); rd(32'd12); idle(6);
    step(1'b1, 1'b1, 32'd8, 32'h55, 1'b0, 32'd0, 32'd0, 1'b1); idle(5);
    rd(32'd8);                    idle(5);
    rd(32'h4000);                 idle(5);
    wr(32'h4000, 32'h77);         idle(5);
    rd(32'd0);                    idle(5);
    wr(32'd20, 32'h1); idle(3); oob(32'd20, 32'h2); idle(2);
    rd(32'd20);                   idle(5);
    rd(32'd24); idle(3); oob(32'd24, 32'hCAFE_0006); idle(2);
    rd(32'd24);                   idle(5);
    oob(32'd0, 32'h11);
    wr(32'd0, 32'hAA); idle(1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0); idle(1);
    rd(32'd0);                    idle(5);
    oob(32'd0, 32'h11);
    wr(32'd0, 32'hAA);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0); idle(1);
    rd(32'd0);                    idle(5);
    for (int i = 0; i < 8; i++) rd(32'd12);
    idle(6);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0:       a = 32'h4000 + 32'($urandom_range(0, 63));
        1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = 32'($urandom_range(0, 127));
      endcase
      step(r < 25, (r >= 25 && r < 40) || r == 40, a, $urandom,
           ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 127)), $urandom,
           ($urandom_range(0, 149) != 0));
    end
    idle(20);
    chk("queue_drain", 0, 32'(q0.size()), 32'd0);
    chk("queue_drain", 1, 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's word memory request interface: mem_addr, mem_rd_req, mem_wr_req, mem_wr_data, mem_rd_data, mem_ack, mem_busy.
- Services one outstanding read or write at a time, after a programmable fixed latency, from an internal word array.
- Out-of-band write port loads programs and data into the array before or while the processor runs.
- Sits between the processor and a future cache or off-chip model; the standard memory model for core testbenches.

Parameters:
LATENCY, 4, cycles from request sample edge to ack edge; legal range 1..16
DEPTH, 4096, number of 32-bit words in the array

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low; asserted when 0
mem_addr  input  32  byte address; word index = mem_addr[31:2]; bits [1:0] ignored
mem_rd_req  input  1  read request, sampled each edge
mem_wr_req  input  1  write request, sampled each edge
mem_wr_data  input  32  write data, captured with mem_wr_req
mem_rd_data  output  32  read data, valid in the ack cycle, held until the next read ack
mem_ack  output  1  one-cycle completion pulse
mem_busy  output  1  high while a request is in service
req_dropped  output  1  one-cycle pulse when a request arrives while busy
oob_wen  input  1  out-of-band write enable
oob_wr_addr  input  32  out-of-band byte address; word index = [31:2]
oob_wr_data  input  32  out-of-band write data

Behaviour:
- Reset, rst low, asynchronous:
  - state IDLE; mem_ack=0, mem_busy=0, req_dropped=0, mem_rd_data=0; counter=0.
  - Any pending request is discarded.
  - Array contents are not cleared; they are preserved across reset.
- States: IDLE, WAIT, ACK.
- IDLE:
  - At edge t, mem_rd_req or mem_wr_req high: latch addr, data and op; busy=1; counter=LATENCY-1; go to WAIT.
  - Both requests high: write takes priority; the read is ignored and req_dropped is not pulsed.
- WAIT:
  - Each edge: if counter != 0, decrement.
  - Edge where counter==0: go to ACK; busy=0; ack=1.
    - Read: mem_rd_data = array[index].
    - Write: array[index] = latched data; mem_rd_data unchanged.
  - Net timing: ack rises at edge t+LATENCY; busy is high for exactly LATENCY cycles. LATENCY=1 means ack is asserted the cycle after the request is sampled.
- ACK:
  - Ack is high for exactly one cycle.
  - A request sampled at the ACK-exit edge is accepted as in IDLE (back-to-back with no bubble); otherwise go to IDLE.
- Requests while in WAIT, or sampled during the busy cycles: ignored, no ack; req_dropped pulses the following cycle.
- Out of range (index >= DEPTH):
  - Reads return 32'h0.
  - Writes are dropped.
  - Both still ack with normal latency.
- oob_wen:
  - Writes array[oob index] at the edge, in any state.
  - Out-of-range oob writes are dropped.
  - Same edge and same word as a front-door write commit: the front-door write wins.
  - Same edge as a read ack of that word: the read returns the old value.
- Read of a word written by an earlier acked write returns the new value (no stale data).
- mem_rd_data changes only at read-ack edges and at reset.
- Reset mid-WAIT: no ack is ever produced for that request, and a write in flight is not committed.

Test Plan:
- LATENCY=4, oob write word 3 = 32'hDEADBEEF; rd_req pulse addr 12 at edge t -> busy high for cycles t..t+3, ack at edge t+4 for 1 cycle with rd_data=32'hDEADBEEF; busy=0 in the ack cycle.
- Write addr 40 data 32'h12345678, then a read of addr 40 issued the cycle after the write ack -> second ack exactly LATENCY cycles later with rd_data=32'h12345678; addr 41 also reads 32'h12345678 (low bits ignored).
- rd_req asserted again 2 cycles into a busy read -> req_dropped pulses once; exactly one ack, for the first read only.
- rd and wr high together, addr 8, wr_data=32'h55 -> write performed, then a later read of addr 8 returns 32'h55; no req_dropped.
- DEPTH=4096: read addr 32'h4000 -> ack after LATENCY, rd_data=0; write there, then oob-read-back via a normal read of the aliased index 0 -> index 0 unchanged.
- Pull rst low at cycle 2 of a LATENCY=4 write to addr 0 with data 32'hAA (array[0] preloaded with 32'h11) -> no ack; after reset a read of addr 0 returns 32'h11. Repeat with LATENCY=1 and check back-to-back reads get acks on consecutive every-other cycles.
